// File: rtl/lsu_if.sv
// Memory-interface bundle for the load/store unit: decode-side request and
// completion signals plus the single-port data-memory bus.
interface lsu_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4
);
    // decode side
    logic                       mem_req;
    logic                       mem_we;
    logic [BYTE_DATA_WIDTH-1:0] byte_enable;
    logic                       signed_flag;
    logic [DATA_WIDTH-1:0]      addr;
    logic [DATA_WIDTH-1:0]      wdata;
    logic                       mem_valid;
    logic [DATA_WIDTH-1:0]      rdata;
    logic                       misaligned;
    // data-memory side
    logic                       dmem_req;
    logic                       dmem_we;
    logic [BYTE_DATA_WIDTH-1:0] dmem_be;
    logic [DATA_WIDTH-1:0]      dmem_addr;
    logic [DATA_WIDTH-1:0]      dmem_wdata;
    logic                       dmem_gnt;
    logic                       dmem_rvalid;
    logic [DATA_WIDTH-1:0]      dmem_rdata;

    // the LSU itself
    modport slave (
        input  mem_req, mem_we, byte_enable, signed_flag, addr, wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output mem_valid, rdata, misaligned,
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata
    );

    // decode unit plus memory model driving the LSU
    modport master (
        output mem_req, mem_we, byte_enable, signed_flag, addr, wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  mem_valid, rdata, misaligned,
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: takes one decode access at a time, checks alignment,
// lane-shifts stores onto the data-memory bus and extends returned load data.
// Every output comes straight from a register.
module lsu #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    lsu_if.slave bus
);
    localparam int OFF_W = $clog2(BYTE_DATA_WIDTH);
    localparam logic [BYTE_DATA_WIDTH-1:0] BE_BYTE = BYTE_DATA_WIDTH'(1);
    localparam logic [BYTE_DATA_WIDTH-1:0] BE_HALF = BYTE_DATA_WIDTH'(3);
    localparam logic [BYTE_DATA_WIDTH-1:0] BE_WORD = '1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e                     state_q;
    // latched access attributes needed after the bus phase
    logic                       we_q;
    logic                       sgn_q;
    logic [BYTE_DATA_WIDTH-1:0] be_q;
    logic [OFF_W-1:0]           off_q;
    // registered outputs
    logic                       mem_valid_q;
    logic                       misaligned_q;
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic                       dmem_req_q;
    logic                       dmem_we_q;
    logic [BYTE_DATA_WIDTH-1:0] dmem_be_q;
    logic [DATA_WIDTH-1:0]      dmem_addr_q;
    logic [DATA_WIDTH-1:0]      dmem_wdata_q;

    logic [OFF_W-1:0]           off_in;
    logic                       mis_d;
    logic [DATA_WIDTH-1:0]      shifted;
    logic [DATA_WIDTH-1:0]      rdata_d;

    assign off_in = bus.addr[OFF_W-1:0];

    // alignment check on the incoming request; unknown size codes are errors
    always_comb begin
        mis_d = 1'b1;
        case (bus.byte_enable)
            BE_BYTE: mis_d = 1'b0;
            BE_HALF: mis_d = off_in[0];
            BE_WORD: mis_d = |off_in;
            default: mis_d = 1'b1;
        endcase
    end

    // move the addressed lane down to bit 0 and extend to full width
    always_comb begin
        shifted = bus.dmem_rdata >> {off_q, 3'b000};
        rdata_d = shifted;
        if (be_q == BE_BYTE)
            rdata_d = {{(DATA_WIDTH-8){sgn_q & shifted[7]}}, shifted[7:0]};
        else if (be_q == BE_HALF)
            rdata_d = {{(DATA_WIDTH-16){sgn_q & shifted[15]}}, shifted[15:0]};
    end

    // access FSM; bus fields are loaded on acceptance so they hold through REQ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            sgn_q        <= 1'b0;
            be_q         <= '0;
            off_q        <= '0;
            mem_valid_q  <= 1'b0;
            misaligned_q <= 1'b0;
            rdata_q      <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_be_q    <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.mem_req) begin
                        we_q  <= bus.mem_we;
                        sgn_q <= bus.signed_flag;
                        be_q  <= bus.byte_enable;
                        off_q <= off_in;
                        if (mis_d) begin
                            // no bus cycle; report the error straight away
                            state_q      <= S_DONE;
                            mem_valid_q  <= 1'b1;
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q      <= S_REQ;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= bus.mem_we;
                            dmem_be_q    <= bus.byte_enable << off_in;
                            dmem_addr_q  <= {bus.addr[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                            dmem_wdata_q <= bus.wdata << {off_in, 3'b000};
                        end
                    end
                end
                S_REQ: begin
                    if (bus.dmem_gnt) begin
                        dmem_req_q   <= 1'b0;
                        dmem_we_q    <= 1'b0;
                        dmem_be_q    <= '0;
                        dmem_addr_q  <= '0;
                        dmem_wdata_q <= '0;
                        if (we_q) begin
                            state_q     <= S_DONE;
                            mem_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.dmem_rvalid) begin
                        rdata_q     <= rdata_d;
                        mem_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    mem_valid_q  <= 1'b0;
                    misaligned_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_valid  = mem_valid_q;
    assign bus.misaligned = misaligned_q;
    assign bus.rdata      = rdata_q;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_be    = dmem_be_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = dmem_wdata_q;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a decode driver plus a configurable memory
// responder; expected completions are queued at issue and compared on
// mem_valid.
module tb_lsu;
    logic clk = 1'b0;
    logic rst;

    lsu_if #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4)) bus ();

    lsu #(.DATA_WIDTH(32), .BYTE_DATA_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mis;
        logic [31:0] rd;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one access; gd = cycles of gnt low in REQ, rvd = cycles from gnt to rvalid
    task automatic do_access(
        input string       tag,
        input logic        we,
        input logic [3:0]  be,
        input logic        sgn,
        input logic [31:0] a,
        input logic [31:0] wd,
        input logic [31:0] rd,
        input int          gd,
        input int          rvd,
        input logic        mis,
        input logic [31:0] exp_rd,
        input logic [31:0] exp_daddr,
        input logic [3:0]  exp_dbe,
        input logic [31:0] exp_dwd
    );
        exp_t e;
        int   k, req_seen, gnt_k, exp_req;
        bit   done;
        e.mis = mis;
        e.rd  = exp_rd;
        e.lat = mis ? 1 : (we ? 2 + gd : 2 + gd + rvd);
        sb.push_back(e);
        exp_req = mis ? 0 : gd + 1;

        bus.mem_req     = 1'b1;
        bus.mem_we      = we;
        bus.byte_enable = be;
        bus.signed_flag = sgn;
        bus.addr        = a;
        bus.wdata       = wd;

        k = 0; req_seen = 0; gnt_k = 0; done = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            if (bus.dmem_req) begin
                req_seen++;
                check({tag, "_daddr"}, 64'(bus.dmem_addr), 64'(exp_daddr));
                check({tag, "_dbe"}, 64'(bus.dmem_be), 64'(exp_dbe));
                check({tag, "_dwdata"}, 64'(bus.dmem_wdata), 64'(exp_dwd));
                check({tag, "_dwe"}, 64'(bus.dmem_we), 64'(we));
                bus.dmem_gnt = (req_seen > gd);
                if (bus.dmem_gnt) gnt_k = k;
            end else begin
                bus.dmem_gnt = 1'b0;
            end
            bus.dmem_rvalid = (gnt_k != 0) && (k == gnt_k + rvd) && !we;
            bus.dmem_rdata  = bus.dmem_rvalid ? rd : (32'h5A5A0000 | 32'(k));
            if (bus.mem_valid) begin
                e = sb.pop_front();
                check({tag, "_latency"}, 64'(k), 64'(e.lat));
                check({tag, "_misaligned"}, 64'(bus.misaligned), 64'(e.mis));
                check({tag, "_rdata"}, 64'(bus.rdata), 64'(e.rd));
                check({tag, "_req_cycles"}, 64'(req_seen), 64'(exp_req));
                done = 1;
                bus.mem_req = 1'b0;
            end
        end
        check({tag, "_completed"}, 64'(done), 64'(1));
        if (!done) begin
            bus.mem_req = 1'b0;
            if (sb.size() > 0) void'(sb.pop_front());
        end
        @(negedge clk);
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        check({tag, "_valid_pulse"}, 64'(bus.mem_valid), 64'(0));
        check({tag, "_rdata_hold"}, 64'(bus.rdata), 64'(exp_rd));
        last_rd = exp_rd;
    endtask

    initial begin
        rst             = 1'b1;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.byte_enable = 4'b0000;
        bus.signed_flag = 1'b0;
        bus.addr        = 32'h0;
        bus.wdata       = 32'h0;
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_mem_valid", 64'(bus.mem_valid), 64'(0));
        check("rst_misaligned", 64'(bus.misaligned), 64'(0));
        check("rst_dmem_req", 64'(bus.dmem_req), 64'(0));
        check("rst_dmem_we", 64'(bus.dmem_we), 64'(0));
        check("rst_dmem_be", 64'(bus.dmem_be), 64'(0));
        check("rst_dmem_addr", 64'(bus.dmem_addr), 64'(0));
        check("rst_dmem_wdata", 64'(bus.dmem_wdata), 64'(0));
        check("rst_rdata", 64'(bus.rdata), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        //        tag     we    be       sgn   addr          wdata         dmem_rdata    gd rvd mis   exp_rdata      daddr         dbe      dwdata
        do_access("sb3",  1'b1, 4'b0001, 1'b0, 32'h00000103, 32'h000000A5, 32'h0,        0, 1, 1'b0, last_rd,       32'h00000100, 4'b1000, 32'hA5000000);
        do_access("lb_s", 1'b0, 4'b0001, 1'b1, 32'h00000201, 32'h0,        32'h12348056, 0, 1, 1'b0, 32'hFFFFFF80,  32'h00000200, 4'b0010, 32'h0);
        do_access("lbu",  1'b0, 4'b0001, 1'b0, 32'h00000201, 32'h0,        32'h12348056, 0, 1, 1'b0, 32'h00000080,  32'h00000200, 4'b0010, 32'h0);
        do_access("lhu",  1'b0, 4'b0011, 1'b0, 32'h00000302, 32'h0,        32'hBEEF1234, 0, 1, 1'b0, 32'h0000BEEF,  32'h00000300, 4'b1100, 32'h0);
        do_access("lh_s", 1'b0, 4'b0011, 1'b1, 32'h00000302, 32'h0,        32'hBEEF1234, 0, 1, 1'b0, 32'hFFFFBEEF,  32'h00000300, 4'b1100, 32'h0);
        do_access("sh2",  1'b1, 4'b0011, 1'b0, 32'h00000102, 32'h1234ABCD, 32'h0,        0, 1, 1'b0, last_rd,       32'h00000100, 4'b1100, 32'hABCD0000);
        do_access("sw_mis", 1'b1, 4'b1111, 1'b0, 32'h00000405, 32'h11223344, 32'h0,      0, 1, 1'b1, last_rd,       32'h0,        4'b0000, 32'h0);
        do_access("lh_mis", 1'b0, 4'b0011, 1'b1, 32'h00000101, 32'h0,      32'h77777777, 0, 1, 1'b1, last_rd,       32'h0,        4'b0000, 32'h0);
        do_access("be_bad", 1'b0, 4'b0101, 1'b0, 32'h00000100, 32'h0,      32'h77777777, 0, 1, 1'b1, last_rd,       32'h0,        4'b0000, 32'h0);
        do_access("lw_ws", 1'b0, 4'b1111, 1'b0, 32'h00000500, 32'h0,       32'hCAFEF00D, 3, 2, 1'b0, 32'hCAFEF00D,  32'h00000500, 4'b1111, 32'h0);
        do_access("sw_ws", 1'b1, 4'b1111, 1'b0, 32'h000007FC, 32'hDEADBEEF, 32'h0,       1, 1, 1'b0, last_rd,       32'h000007FC, 4'b1111, 32'hDEADBEEF);

        // reset while a load sits in WAIT
        bus.mem_req     = 1'b1;
        bus.mem_we      = 1'b0;
        bus.byte_enable = 4'b1111;
        bus.signed_flag = 1'b0;
        bus.addr        = 32'h00000600;
        bus.wdata       = 32'h0;
        @(negedge clk);
        check("rst_mid_req_seen", 64'(bus.dmem_req), 64'(1));
        bus.dmem_gnt = 1'b1;
        @(negedge clk);
        bus.dmem_gnt = 1'b0;
        bus.mem_req  = 1'b0;
        check("rst_mid_in_wait", 64'(bus.dmem_req), 64'(0));
        rst = 1'b1;
        #1;
        check("rst_mid_dmem_req", 64'(bus.dmem_req), 64'(0));
        check("rst_mid_mem_valid", 64'(bus.mem_valid), 64'(0));
        check("rst_mid_rdata", 64'(bus.rdata), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        last_rd = 32'h0;
        @(negedge clk);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h13572468;
        @(negedge clk);
        bus.dmem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stray_rvalid_valid", 64'(bus.mem_valid), 64'(0));
            check("stray_rvalid_rdata", 64'(bus.rdata), 64'(0));
            @(negedge clk);
        end

        do_access("lw_post", 1'b0, 4'b1111, 1'b0, 32'h00000700, 32'h0,     32'h89ABCDEF, 0, 1, 1'b0, 32'h89ABCDEF,  32'h00000700, 4'b1111, 32'h0);
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the responder end of the decode unit's memory interface (`mem_req`/`mem_we`/`byte_enable` → `mem_valid`). It accepts one access at a time and performs lane alignment and byte-enable shifting for stores. It drives a single-port data-memory bus with grant/read-valid handshake and returns sign- or zero-extended load data for the register file.

## Interface
- `DATA_WIDTH`, 32, data and address width
- `BYTE_DATA_WIDTH`, 4, byte lanes per word (DATA_WIDTH/8)
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `mem_req` in 1: access request from decode, held high until `mem_valid`
- `mem_we` in 1: 1 = store, 0 = load
- `byte_enable` in BYTE_DATA_WIDTH: size code relative to lane 0: 0001 byte, 0011 half, 1111 word
- `signed_flag` in 1: loads only; 1 = sign-extend, 0 = zero-extend
- `addr` in DATA_WIDTH: byte address from the ALU
- `wdata` in DATA_WIDTH: store data (rs2), right-aligned
- `mem_valid` out 1: one-cycle completion pulse
- `rdata` out DATA_WIDTH: extended load result, valid with `mem_valid`, held until the next load completes
- `misaligned` out 1: error flag, pulses with `mem_valid`
- `dmem_req` out 1: data-memory request
- `dmem_we` out 1: data-memory write enable
- `dmem_be` out BYTE_DATA_WIDTH: lane enables
- `dmem_addr` out DATA_WIDTH: word address, bits [1:0] = 00
- `dmem_wdata` out DATA_WIDTH: lane-shifted store data
- `dmem_gnt` in 1: memory accepted the request
- `dmem_rvalid` in 1: read data valid
- `dmem_rdata` in DATA_WIDTH: raw word read data

## Operation
**States:** IDLE, REQ, WAIT, DONE.

- **IDLE**
  - When `mem_req`=1, latch `addr`, `mem_we`, `byte_enable`, `wdata` and `signed_flag`.
  - Misalignment check. The access is misaligned when any of these holds:
    - half access with addr[0]=1;
    - word access with addr[1:0]≠00;
    - `byte_enable` is not 0001, 0011 or 1111.
  - Misaligned → DONE with the error latched. No memory access is made and `rdata` is unchanged.
  - Aligned → REQ.
- **REQ**
  - Drive the bus from the latched request (registered values, stable through REQ):
    - `dmem_req`=1;
    - `dmem_we`=latched we;
    - `dmem_addr`={addr[31:2],00};
    - `dmem_be`=be << addr[1:0];
    - `dmem_wdata`=wdata << 8·addr[1:0].
  - On `dmem_gnt`: a store goes to DONE, a load goes to WAIT. Otherwise stay in REQ (wait states are unbounded).
- **WAIT**
  - `dmem_req`=0.
  - On `dmem_rvalid`:
    - compute s = `dmem_rdata` >> 8·addr[1:0];
    - byte → extend s[7];
    - half → extend s[15];
    - word → s unchanged;
    - extension is sign (`signed_flag`=1) or zero (`signed_flag`=0);
    - register the result into `rdata` and go to DONE.
  - `dmem_rvalid` is ignored in every state except WAIT.
- **DONE**
  - `mem_valid`=1, and `misaligned`=latched error, for exactly one cycle, then IDLE.
  - `mem_req` is not sampled in DONE. Decode drops `mem_req` on the cycle after `mem_valid`; if it is still high in IDLE, that is a new access.
- `dmem_be`, `dmem_wdata` and `dmem_addr` are don't-care outside REQ but driven to 0 in IDLE.

## Timing
- **Reset values:** state IDLE; `mem_valid`, `misaligned`, `dmem_req`, `dmem_we` = 0; `dmem_be`, `dmem_addr`, `dmem_wdata`, `rdata` = 0.
- **Reset mid-operation:** state and outputs clear asynchronously. `dmem_req` drops immediately. A late `dmem_rvalid` after reset is ignored.
- **Request sampling:** `mem_req` is sampled at edge T0, in IDLE.
- **Best-case store:** REQ in T0+1 with `dmem_gnt`=1 → DONE, so `mem_valid` is high in cycle T0+2.
- **Best-case load:** `dmem_gnt` in T0+1, `dmem_rvalid` in T0+2 → `mem_valid` and `rdata` in T0+3.
- **Misaligned:** `mem_valid`=`misaligned`=1 in T0+1.
- **Wait states:**
  - Each cycle of `dmem_gnt`=0 in REQ adds one cycle.
  - Each cycle of `dmem_rvalid`=0 in WAIT adds one cycle.
- **Memory guarantee:** `dmem_rvalid` arrives no earlier than the cycle after `dmem_gnt`.
- **Throughput:** at most one access per 3 cycles (store) or 4 cycles (load).
- **All outputs** are registered or decoded from the state register only; there is no combinational path from `dmem_*` inputs to outputs.

## Test plan
- **Store byte at offset 3:** SB, `addr`=0x103, `wdata`=0x000000A5, `dmem_gnt` tied 1.
  - Expect `dmem_addr`=0x100, `dmem_be`=1000, `dmem_wdata`=0xA5000000.
  - Expect `mem_valid` 2 cycles after request.
- **Signed byte load:** LB signed, `addr`=0x201, `dmem_rdata`=0x12348056.
  - Expect `rdata`=0xFFFFFF80, `mem_valid` at T0+3.
  - Repeat unsigned: expect `rdata`=0x00000080.
- **Unsigned half load:** LHU, `addr`=0x302, `dmem_rdata`=0xBEEF1234.
  - Expect `dmem_be`=1100, `rdata`=0x0000BEEF.
- **Misaligned word:** SW, `addr`=0x405.
  - Expect `mem_valid`=`misaligned`=1 at T0+1.
  - Expect `dmem_req` never asserted and `rdata` unchanged.
- **Wait states:** LW, `addr`=0x500, `dmem_gnt` low 3 cycles, `dmem_rvalid` 2 cycles after `gnt`, `dmem_rdata`=0xCAFEF00D.
  - Expect `dmem_req` held stable for 4 cycles.
  - Expect `mem_valid` at T0+7 with `rdata`=0xCAFEF00D.
- **Reset mid-operation:** assert `rst` during WAIT.
  - Expect `dmem_req`=0, `mem_valid`=0, `rdata`=0 immediately.
  - A subsequent stray `dmem_rvalid` produces no `mem_valid`.
  - The next LW completes normally.
